// File: rtl/elev_pkg.sv
// Shared types and direction encodings for the SCAN elevator controller.
package elev_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVING,
    S_DOORS
  } state_e;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  function automatic logic [1:0] dir_flip(input logic [1:0] d);
    return (d == DIR_UP) ? DIR_DN : DIR_UP;
  endfunction

endpackage

// File: rtl/elev_req_table.sv
// Latched call table: range check, set/clear of pending bits and
// above/below/at-floor lookups for the SCAN controller.
module elev_req_table
  import elev_pkg::*;
#(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic [FLOOR_W-1:0]    next_floor,
  input  logic                  in_doors,
  input  logic                  clr_en,
  input  logic [FLOOR_W-1:0]    clr_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  req_err,
  output logic                  reopen,
  output logic                  here_pend,
  output logic                  next_pend,
  output logic                  ahead_up,
  output logic                  ahead_dn
);

  localparam logic [FLOOR_W:0] NF = (FLOOR_W + 1)'(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] pend_q, pend_d;
  logic [NUM_FLOORS-1:0] up_mask, dn_mask, cur_mask, nxt_mask, set_mask, clr_mask;
  logic                  err_q, err_d;
  logic                  in_range;

  assign in_range = ({1'b0, req_floor} < NF);
  assign reopen   = req_valid && in_range && in_doors && (req_floor == cur_floor);
  assign err_d    = req_valid && !in_range;

  // Masks are built by comparison so a wider floor index never selects past the table.
  always_comb begin
    up_mask  = '0;
    dn_mask  = '0;
    cur_mask = '0;
    nxt_mask = '0;
    set_mask = '0;
    clr_mask = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      up_mask[i]  = (i > 32'(cur_floor));
      dn_mask[i]  = (i < 32'(cur_floor));
      cur_mask[i] = (i == 32'(cur_floor));
      nxt_mask[i] = (i == 32'(next_floor));
      set_mask[i] = req_valid && in_range && !reopen && (i == 32'(req_floor));
      clr_mask[i] = clr_en && (i == 32'(clr_floor));
    end
    pend_d = (pend_q | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign pending   = pend_q;
  assign req_err   = err_q;
  assign here_pend = |(pend_q & cur_mask);
  assign next_pend = |(pend_q & nxt_mask);
  assign ahead_up  = |(pend_q & up_mask);
  assign ahead_dn  = |(pend_q & dn_mask);

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Single-car collective (SCAN) elevator controller: FSM, travel and door
// timers around the latched request table.
module elevator_scan_ctrl
  import elev_pkg::*;
#(
  parameter int NUM_FLOORS    = 4,
  parameter int FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int TRAVEL_CYCLES = 50000000,
  parameter int DOOR_CYCLES   = 100000000,
  parameter int RESET_FLOOR   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic                  req_err,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [FLOOR_W-1:0]    floor,
  output logic [1:0]            direction,
  output logic                  doors_open,
  output logic                  busy,
  output logic                  arrived
);

  localparam int TW = $clog2(TRAVEL_CYCLES);
  localparam int DW = $clog2(DOOR_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DLAST = DW'(DOOR_CYCLES - 1);

  state_e             state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d, nf;
  logic [1:0]         dir_q, dir_d, last_dir_q, last_dir_d;
  logic [TW-1:0]      travel_q, travel_d;
  logic [DW-1:0]      door_q, door_d;
  logic               arrived_q, arrived_d;

  logic               clr_en;
  logic [FLOOR_W-1:0] clr_floor;
  logic               reopen, here_pend, next_pend, ahead_up, ahead_dn;
  logic               ahead_same, ahead_other;

  assign nf          = (dir_q == DIR_DN) ? floor_q - FLOOR_W'(1) : floor_q + FLOOR_W'(1);
  assign ahead_same  = (last_dir_q == DIR_UP) ? ahead_up : ahead_dn;
  assign ahead_other = (last_dir_q == DIR_UP) ? ahead_dn : ahead_up;

  elev_req_table #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_req_table (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_floor  (req_floor),
    .cur_floor  (floor_q),
    .next_floor (nf),
    .in_doors   (state_q == S_DOORS),
    .clr_en     (clr_en),
    .clr_floor  (clr_floor),
    .pending    (pending),
    .req_err    (req_err),
    .reopen     (reopen),
    .here_pend  (here_pend),
    .next_pend  (next_pend),
    .ahead_up   (ahead_up),
    .ahead_dn   (ahead_dn)
  );

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    travel_d   = travel_q;
    door_d     = door_q;
    arrived_d  = 1'b0;
    clr_en     = 1'b0;
    clr_floor  = floor_q;
    unique case (state_q)
      S_IDLE: begin
        if (here_pend) begin
          state_d   = S_DOORS;
          door_d    = '0;
          clr_en    = 1'b1;
          arrived_d = 1'b1;
        end else if (ahead_same) begin
          state_d  = S_MOVING;
          dir_d    = last_dir_q;
          travel_d = '0;
        end else if (ahead_other) begin
          state_d    = S_MOVING;
          dir_d      = dir_flip(last_dir_q);
          last_dir_d = dir_flip(last_dir_q);
          travel_d   = '0;
        end else begin
          dir_d = DIR_NONE;
        end
      end
      S_MOVING: begin
        if (travel_q == TLAST) begin
          travel_d = '0;
          floor_d  = nf;
          if (next_pend) begin
            state_d   = S_DOORS;
            door_d    = '0;
            clr_en    = 1'b1;
            clr_floor = nf;
            arrived_d = 1'b1;
          end
        end else begin
          travel_d = travel_q + TW'(1);
        end
      end
      S_DOORS: begin
        // A same-floor call on the closing cycle still wins and holds the doors.
        if (reopen) begin
          door_d = '0;
        end else if (door_q == DLAST) begin
          door_d = '0;
          if (ahead_same) begin
            state_d  = S_MOVING;
            dir_d    = last_dir_q;
            travel_d = '0;
          end else if (ahead_other) begin
            state_d    = S_MOVING;
            dir_d      = dir_flip(last_dir_q);
            last_dir_d = dir_flip(last_dir_q);
            travel_d   = '0;
          end else begin
            state_d = S_IDLE;
            dir_d   = DIR_NONE;
          end
        end else begin
          door_d = door_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      floor_q    <= FLOOR_W'(RESET_FLOOR);
      dir_q      <= DIR_NONE;
      last_dir_q <= DIR_UP;
      travel_q   <= '0;
      door_q     <= '0;
      arrived_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      travel_q   <= travel_d;
      door_q     <= door_d;
      arrived_q  <= arrived_d;
    end
  end

  assign floor      = floor_q;
  assign direction  = dir_q;
  assign doors_open = (state_q == S_DOORS);
  assign busy       = (state_q != S_IDLE);
  assign arrived    = arrived_q;

endmodule
